uart_port_master: RTL and testbench
===================================

# uart_port_master

Hardware command initiator that sits between the UART RX/TX FIFOs and the 8-bit port bus of the command/control hub, taking the bus-master role normally played by the soft processor. It parses byte frames from the host: a write frame drives a port write, and a read frame performs a port read and returns the byte over UART. It lets the host poke LogCap registers, commands and LEDs with no firmware running.

## Interface
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles between bytes of one frame (10 ms at 100 MHz) before the partial frame is dropped.
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- data_rx  in  8  head byte of the RX FIFO; valid while urx_buffer_data_present=1.
- urx_buffer_data_present  in  1  RX FIFO non-empty.
- urx_buffer_read  out  1  one-cycle pop of the RX FIFO.
- data_tx  out  8  byte to push into the TX FIFO.
- utx_buffer_full  in  1  TX FIFO full.
- utx_buffer_write  out  1  one-cycle push into the TX FIFO.
- port_id  out  8  port address.
- port_out  out  8  write data.
- write_strobe  out  1  one-cycle port write.
- read_strobe  out  1  one-cycle port read.
- port_in  in  8  read data; registered by the hub, valid one cycle after port_id settles.
- busy  out  1  high whenever the FSM is not in IDLE.
- error  out  1  one-cycle pulse on a bad opcode or an inter-byte timeout.

## Operation
- Frames:
  - Write: 0x57 ('W'), addr, data. Performs the port write, then replies 0x06 (ACK).
  - Read: 0x52 ('R'), addr. Performs the port read, then replies with the read byte.
  - Any other first byte: reply 0x15 (NAK) and pulse error.
- Byte fetch: when urx_buffer_data_present=1 in a receive state, capture data_rx and pulse urx_buffer_read in the same cycle. The following cycle is a mandatory settle cycle with no pop, so the FIFO flags can update.
- FSM states:
  - IDLE: wait for a byte. Opcode byte -> GET_ADDR; unknown byte -> SEND with NAK.
  - GET_ADDR: wait for addr. Write frame -> GET_DATA; read frame -> RD_SETUP.
  - GET_DATA: wait for data -> WR.
  - WR: one cycle with write_strobe=1 -> WR_HOLD.
  - WR_HOLD: one cycle -> SEND with ACK.
  - RD_SETUP: one cycle -> RD_CAP.
  - RD_CAP: one cycle; latch port_in -> SEND.
  - SEND: wait for utx_buffer_full=0, pulse utx_buffer_write -> IDLE.
- Timeout: the counter runs only in GET_ADDR and GET_DATA, and reloads on every fetched byte. At count = TIMEOUT_CYCLES-1: return to IDLE, send no reply, pulse error.
- Counter width is clog2(TIMEOUT_CYCLES). Counter saturation is impossible because the counter clears on state exit.
- SEND back-pressure has no timeout. The FSM stalls indefinitely while utx_buffer_full=1, and RX bytes stay queued in the FIFO.
- The full 8-bit address is driven on port_id. Decoding is the hub's responsibility.

## Timing
- Reset values: port_id, port_out and data_tx = 0x00. All strobes, busy and error = 0. FSM in IDLE, timeout counter = 0.
- Reset mid-operation: outputs return to reset values asynchronously and any partial frame is discarded. A strobe cut short by reset is not reissued.
- Write: port_id and port_out are stable from the WR cycle through WR_HOLD, so they are stable one cycle before and one cycle after write_strobe.
- Read: port_id is stable in RD_SETUP and RD_CAP. read_strobe=1 only in RD_CAP, and port_in is sampled at the end of RD_CAP.
- Byte-to-byte minimum: 2 cycles (fetch + settle).
- Latency for a write, from popping the last data byte to utx_buffer_write (TX not full): 4 cycles — settle, WR, WR_HOLD, SEND.
- Latency for a read, from popping addr to utx_buffer_write: 4 cycles — settle, RD_SETUP, RD_CAP, SEND.
- At most one of write_strobe, read_strobe, urx_buffer_read or utx_buffer_write is high in any cycle.
- data_tx is stable in the utx_buffer_write cycle and holds until the next SEND.
- Timeout firing in the same cycle a byte arrives: the byte wins and the counter reloads.

## Structure
- Shared package uart_port_master_pkg holds:
  - opcode constants OP_WRITE = 8'h57 and OP_READ = 8'h52;
  - reply constants RSP_ACK = 8'h06 and RSP_NAK = 8'h15;
  - the FSM state enum.
- One sub-module: uart_frame_timer, a loadable down-counter with clear, load and expired signals, parameterised by TIMEOUT_CYCLES.

## Test plan
- Write frame: RX 57 0A 3C -> exactly one write_strobe with port_id=0x0A, port_out=0x3C; then TX 0x06. error never pulses.
- Read frame: RX 52 03, with the hub model returning 0xA5 one cycle after port_id=0x03 -> read_strobe only in the cycle port_in=0xA5; TX 0xA5.
- Bad opcode: RX 0x41 -> TX 0x15, one error pulse, no port strobes; a following 52 08 frame completes normally.
- Timeout: RX 57 0A, then idle for TIMEOUT_CYCLES (set to 16 in the bench) -> error pulse, no strobe, no TX, FSM back in IDLE; a following 57 0B 01 frame completes with an ACK.
- Back-pressure and reset: hold utx_buffer_full=1 during a read reply -> busy stays 1 and utx_buffer_write stays 0 until full drops, then the byte is sent. Assert reset during GET_DATA -> all outputs go to 0 immediately and the partial frame is never executed.

Source files
------------

// File: rtl/uart_port_master_pkg.sv
// Shared constants and FSM state encoding for the UART-driven port bus master.
package uart_port_master_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WR,
    ST_WR_HOLD,
    ST_RD_SETUP,
    ST_RD_CAP,
    ST_SEND
  } state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_port_master_if.sv
// FIFO-side and port-bus signals of the UART port master, grouped for binding.
// Handshakes: urx_buffer_read pops the RX head only while urx_buffer_data_present=1;
// utx_buffer_write pushes data_tx only while utx_buffer_full=0; strobes are one cycle.
interface uart_port_master_if;
  logic [7:0] data_rx;
  logic       urx_buffer_data_present;
  logic       urx_buffer_read;
  logic [7:0] data_tx;
  logic       utx_buffer_full;
  logic       utx_buffer_write;
  logic [7:0] port_id;
  logic [7:0] port_out;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] port_in;
  logic       busy;
  logic       error;

  modport master (
    input  data_rx, urx_buffer_data_present, utx_buffer_full, port_in,
    output urx_buffer_read, data_tx, utx_buffer_write, port_id, port_out,
    output write_strobe, read_strobe, busy, error
  );

  modport slave (
    output data_rx, urx_buffer_data_present, utx_buffer_full, port_in,
    input  urx_buffer_read, data_tx, utx_buffer_write, port_id, port_out,
    input  write_strobe, read_strobe, busy, error
  );
endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout: loadable down-counter; expired while running and at zero.
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over clear so a state exit that also starts a new wait reloads.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = LOAD_VAL;
    else if (clear_i)               cnt_d = '0;
    else if (run_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == '0);
endmodule

// File: rtl/uart_port_master.sv
// Parses W/R byte frames from the UART RX FIFO, drives the 8-bit port bus,
// and replies ACK, NAK or the read byte through the TX FIFO.
module uart_port_master
  import uart_port_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_port_master_if.master   bus,
  output state_e               dbg_state_o
);
  state_e     state_q;
  logic       settle_q;
  logic [7:0] op_q;
  logic [7:0] port_id_q, port_out_q, data_tx_q;
  logic       wr_stb_q, rd_stb_q, err_q;

  logic rx_state, pop, tx_push, tmr_run, tmr_load, tmr_clear, tmr_expired;

  // After every pop the next cycle is a settle cycle: no pop, then advance.
  assign rx_state  = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) ||
                     (state_q == ST_GET_DATA);
  assign pop       = rx_state && !settle_q && bus.urx_buffer_data_present;
  assign tx_push   = (state_q == ST_SEND) && !bus.utx_buffer_full;
  assign tmr_run   = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign tmr_load  = pop || settle_q;
  assign tmr_clear = !tmr_run;

  uart_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (tmr_clear),
    .load_i    (tmr_load),
    .run_i     (tmr_run),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      settle_q   <= 1'b0;
      op_q       <= 8'h00;
      port_id_q  <= 8'h00;
      port_out_q <= 8'h00;
      data_tx_q  <= 8'h00;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            op_q     <= bus.data_rx;
            settle_q <= 1'b1;
          end else if (settle_q) begin
            settle_q <= 1'b0;
            if (is_opcode(op_q)) begin
              state_q <= ST_GET_ADDR;
            end else begin
              data_tx_q <= RSP_NAK;
              err_q     <= 1'b1;
              state_q   <= ST_SEND;
            end
          end
        end
        ST_GET_ADDR: begin
          if (pop) begin
            port_id_q <= bus.data_rx;
            settle_q  <= 1'b1;
          end else if (settle_q) begin
            settle_q <= 1'b0;
            state_q  <= (op_q == OP_WRITE) ? ST_GET_DATA : ST_RD_SETUP;
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (pop) begin
            port_out_q <= bus.data_rx;
            settle_q   <= 1'b1;
          end else if (settle_q) begin
            settle_q <= 1'b0;
            wr_stb_q <= 1'b1;
            state_q  <= ST_WR;
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WR:       state_q <= ST_WR_HOLD;
        ST_WR_HOLD: begin
          data_tx_q <= RSP_ACK;
          state_q   <= ST_SEND;
        end
        ST_RD_SETUP: begin
          rd_stb_q <= 1'b1;
          state_q  <= ST_RD_CAP;
        end
        // port_in is registered by the hub off port_id, so it is valid here.
        ST_RD_CAP: begin
          data_tx_q <= bus.port_in;
          state_q   <= ST_SEND;
        end
        ST_SEND: if (tx_push) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.urx_buffer_read  = pop;
  assign bus.utx_buffer_write = tx_push;
  assign bus.data_tx          = data_tx_q;
  assign bus.port_id          = port_id_q;
  assign bus.port_out         = port_out_q;
  assign bus.write_strobe     = wr_stb_q;
  assign bus.read_strobe      = rd_stb_q;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.error            = err_q;
  assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_uart_port_master.sv
// Directed bench for uart_port_master: RX FIFO and hub models, scoreboard queues.
module tb_uart_port_master;
  import uart_port_master_pkg::*;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_port_master_if bus();
  state_e dbg_state;

  uart_port_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int last_err_cyc = 0;
  int err_cnt = 0;
  int tx_cnt = 0;
  logic [7:0]  rx_fifo[$];
  logic [7:0]  exp_q[$];
  int          exp_lat_q[$];
  logic [15:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic        rx_pop_pend = 1'b0;
  logic        wr_prev = 1'b0;
  logic [15:0] bus_prev = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hub_val(input logic [7:0] addr);
    case (addr)
      8'h03:   return 8'hA5;
      8'h08:   return 8'hAE;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- FIFO / hub models ----------------
  always @(posedge clk) rx_pop_pend <= bus.urx_buffer_read;
  always @(posedge clk) bus.port_in <= hub_val(bus.port_id);

  // RX FIFO flags update just after the edge that pops.
  always @(posedge clk) begin
    #2;
    if (rx_pop_pend && rx_fifo.size() != 0) rx_fifo.delete(0);
    bus.urx_buffer_data_present = (rx_fifo.size() != 0);
    bus.data_rx = (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00;
  end

  initial bus.utx_buffer_full = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] e16;
    logic [7:0]  e8;
    int          lat;
    cyc++;
    if (bus.urx_buffer_read) last_rd_cyc = cyc;
    if (bus.error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.write_strobe | bus.read_strobe | bus.urx_buffer_read | bus.utx_buffer_write)
      check("strobe_onehot", 32'($countones({bus.write_strobe, bus.read_strobe,
                                              bus.urx_buffer_read, bus.utx_buffer_write})), 32'd1);
    if (wr_prev) check("wr_hold_after", 32'({bus.port_id, bus.port_out}), 32'(bus_prev));
    if (bus.write_strobe) begin
      check("wr_setup_before", 32'({bus.port_id, bus.port_out}), 32'(bus_prev));
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", 32'({bus.port_id, bus.port_out}), 32'hFFFF_FFFF);
      end else begin
        e16 = exp_wr_q.pop_front();
        check("wr_addr_data", 32'({bus.port_id, bus.port_out}), 32'(e16));
      end
    end
    if (bus.read_strobe) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_unexpected", 32'({bus.port_id, bus.port_in}), 32'hFFFF_FFFF);
      end else begin
        e16 = exp_rd_q.pop_front();
        check("rd_addr_data", 32'({bus.port_id, bus.port_in}), 32'(e16));
      end
    end
    if (bus.utx_buffer_write) begin
      tx_cnt++;
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'(bus.data_tx), 32'hFFFF_FFFF);
      end else begin
        e8  = exp_q.pop_front();
        lat = exp_lat_q.pop_front();
        check("tx_byte", 32'(bus.data_tx), 32'(e8));
        if (lat >= 0) check("tx_latency", 32'(cyc - last_rd_cyc), 32'(lat));
      end
    end
    wr_prev  = bus.write_strobe;
    bus_prev = {bus.port_id, bus.port_out};
  end

  // ---------------- driver tasks ----------------
  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
    logic [7:0] bs[3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int i = 0; i < n; i++) rx_fifo.push_back(bs[i]);
  endtask

  task automatic expect_tx(input logic [7:0] b, input int lat);
    exp_q.push_back(b);
    exp_lat_q.push_back(lat);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rx_fifo.size() != 0 || dbg_state != ST_IDLE) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n >= 300), 32'd0);
  endtask

  task automatic set_full(input logic v);
    @(posedge clk);
    #2 bus.utx_buffer_full = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int tx_before;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_strobes", 32'({bus.write_strobe, bus.read_strobe, bus.urx_buffer_read,
                                bus.utx_buffer_write, bus.busy, bus.error}), 32'd0);
    check("reset_bus", 32'({bus.port_id, bus.port_out, bus.data_tx}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // Write frame 57 0A 3C
    exp_wr_q.push_back(16'h0A3C);
    expect_tx(8'h06, 4);
    push_bytes(8'h57, 8'h0A, 8'h3C, 3);
    wait_done("write_done");
    check("write_no_error", 32'(err_cnt), 32'd0);
    check("tx_hold_idle", 32'(bus.data_tx), 32'h06);

    // Read frame 52 03 -> hub returns A5
    exp_rd_q.push_back(16'h03A5);
    expect_tx(8'hA5, 4);
    push_bytes(8'h52, 8'h03, 8'h00, 2);
    wait_done("read_done");

    // Bad opcode then a normal read
    expect_tx(8'h15, 2);
    push_bytes(8'h41, 8'h00, 8'h00, 1);
    wait_done("nak_done");
    check("nak_error_pulse", 32'(err_cnt), 32'd1);
    exp_rd_q.push_back(16'h08AE);
    expect_tx(8'hAE, 4);
    push_bytes(8'h52, 8'h08, 8'h00, 2);
    wait_done("read_after_nak_done");

    // Timeout mid-frame, then a fresh write frame
    tx_before = tx_cnt;
    push_bytes(8'h57, 8'h0A, 8'h00, 2);
    n = 0;
    while (err_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_fired", 32'(err_cnt), 32'd2);
    check("timeout_window", 32'(((last_err_cyc - last_rd_cyc) >= TMO) &&
                                ((last_err_cyc - last_rd_cyc) <= TMO + 3)), 32'd1);
    @(negedge clk);
    check("timeout_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("timeout_no_tx", 32'(tx_cnt), 32'(tx_before));
    exp_wr_q.push_back(16'h0B01);
    expect_tx(8'h06, 4);
    push_bytes(8'h57, 8'h0B, 8'h01, 3);
    wait_done("write_after_timeout_done");

    // Back-pressure on the read reply
    set_full(1'b1);
    tx_before = tx_cnt;
    exp_rd_q.push_back(16'h03A5);
    expect_tx(8'hA5, -1);
    push_bytes(8'h52, 8'h03, 8'h00, 2);
    repeat (20) @(negedge clk);
    check("bp_busy", 32'(bus.busy), 32'd1);
    check("bp_state", 32'(dbg_state), 32'(ST_SEND));
    check("bp_no_tx", 32'(tx_cnt), 32'(tx_before));
    set_full(1'b0);
    wait_done("bp_done");
    check("bp_sent", 32'(tx_cnt), 32'(tx_before + 1));

    // Reset during GET_DATA drops the partial frame
    push_bytes(8'h57, 8'h0C, 8'h00, 2);
    n = 0;
    while (dbg_state != ST_GET_DATA && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_get_data", 32'(dbg_state), 32'(ST_GET_DATA));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_strobes", 32'({bus.write_strobe, bus.read_strobe, bus.urx_buffer_read,
                                      bus.utx_buffer_write, bus.busy, bus.error}), 32'd0);
    check("async_reset_bus", 32'({bus.port_id, bus.port_out, bus.data_tx}), 32'd0);
    check("async_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("post_reset_no_error", 32'(err_cnt), 32'd2);

    // Recovery read after reset
    exp_rd_q.push_back(16'h03A5);
    expect_tx(8'hA5, 4);
    push_bytes(8'h52, 8'h03, 8'h00, 2);
    wait_done("read_after_reset_done");

    repeat (5) @(negedge clk);
    check("queues_drained", 32'(exp_q.size() + exp_wr_q.size() + exp_rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
